decode_issue: RTL and testbench

//  ID stage of the pipelined MIPS core; the producer side of the ALU operand interface. Accepts

---
 rtl/decode_issue_if.sv | 30 +++
 rtl/decode_issue.sv | 239 +++++++++++++++++++++++
 tb/tb_decode_issue.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/decode_issue_if.sv
// ID/EX pipeline register bundle: the ALU operands and control that decode_issue
// hands to the EX stage each cycle.
interface decode_issue_if;
  logic        ex_valid;
  logic [5:0]  ex_opcode;
  logic [5:0]  ex_func;
  logic [4:0]  ex_sa;
  logic [31:0] ex_first_val;
  logic [31:0] ex_second_val;
  logic [31:0] ex_store_data;
  logic [4:0]  ex_waddr;
  logic        ex_we;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic        ex_is_branch;
  logic        ex_is_jump;
  logic [31:0] ex_target;

  modport master (
    output ex_valid, ex_opcode, ex_func, ex_sa, ex_first_val, ex_second_val,
           ex_store_data, ex_waddr, ex_we, ex_mem_read, ex_mem_write,
           ex_is_branch, ex_is_jump, ex_target
  );

  modport slave (
    input ex_valid, ex_opcode, ex_func, ex_sa, ex_first_val, ex_second_val,
          ex_store_data, ex_waddr, ex_we, ex_mem_read, ex_mem_write,
          ex_is_branch, ex_is_jump, ex_target
  );
endinterface

// File: rtl/decode_issue.sv
// MIPS ID stage: decodes, reads and forwards operands, inserts load-use bubbles
// and registers everything the EX stage needs into the ID/EX register.
module decode_issue #(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   if_valid,
  input  logic [31:0]            if_instr,
  input  logic [31:0]            if_pc,
  output logic                   id_ready,
  input  logic                   flush,
  output logic [4:0]             rf_raddr1,
  output logic [4:0]             rf_raddr2,
  input  logic [31:0]            rf_rdata1,
  input  logic [31:0]            rf_rdata2,
  input  logic                   fwd_ex_we,
  input  logic [4:0]             fwd_ex_waddr,
  input  logic [31:0]            fwd_ex_wdata,
  input  logic                   fwd_mem_we,
  input  logic [4:0]             fwd_mem_waddr,
  input  logic [31:0]            fwd_mem_wdata,
  decode_issue_if.master         ex_if,
  output logic                   illegal_instr,
  output logic [STALL_CNT_W-1:0] stall_count
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] FUNC_JR  = 6'b001000;

  typedef enum logic {RUN, STALL} state_t;
  state_t state, state_next;

  logic [5:0]  opcode, func;
  logic [4:0]  rs, rt, rd;
  logic [31:0] sext_imm, zext_imm, pc4, br_target, j_target;
  logic [31:0] rs_val, rt_val;

  assign opcode    = if_instr[31:26];
  assign rs        = if_instr[25:21];
  assign rt        = if_instr[20:16];
  assign rd        = if_instr[15:11];
  assign func      = if_instr[5:0];
  assign sext_imm  = {{16{if_instr[15]}}, if_instr[15:0]};
  assign zext_imm  = {16'h0000, if_instr[15:0]};
  assign pc4       = if_pc + 32'd4;
  assign br_target = pc4 + {sext_imm[29:0], 2'b00};
  assign j_target  = {pc4[31:28], if_instr[25:0], 2'b00};
  assign rf_raddr1 = rs;
  assign rf_raddr2 = rt;

  // Youngest producer wins: EX/MEM result, then MEM/WB writeback, then the regfile.
  function automatic logic [31:0] read_operand(
    input logic [4:0]  addr,
    input logic [31:0] rf,
    input logic        ewe,
    input logic [4:0]  ea,
    input logic [31:0] ed,
    input logic        mwe,
    input logic [4:0]  ma,
    input logic [31:0] md
  );
    if (addr == 5'd0)            return 32'd0;
    else if (ewe && ea == addr)  return ed;
    else if (mwe && ma == addr)  return md;
    else                         return rf;
  endfunction

  assign rs_val = read_operand(rs, rf_rdata1, fwd_ex_we, fwd_ex_waddr, fwd_ex_wdata,
                               fwd_mem_we, fwd_mem_waddr, fwd_mem_wdata);
  assign rt_val = read_operand(rt, rf_rdata2, fwd_ex_we, fwd_ex_waddr, fwd_ex_wdata,
                               fwd_mem_we, fwd_mem_waddr, fwd_mem_wdata);

  logic [31:0] d_first, d_second, d_target;
  logic [4:0]  d_waddr;
  logic        d_we_raw, d_we, d_mr, d_mw, d_br, d_jp, d_illegal, use_rs, use_rt;

  always_comb begin
    d_first   = 32'd0;
    d_second  = 32'd0;
    d_target  = 32'd0;
    d_waddr   = 5'd0;
    d_we_raw  = 1'b0;
    d_mr      = 1'b0;
    d_mw      = 1'b0;
    d_br      = 1'b0;
    d_jp      = 1'b0;
    d_illegal = 1'b0;
    use_rs    = 1'b0;
    use_rt    = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        d_first  = rs_val;
        d_second = rt_val;
        d_waddr  = rd;
        use_rs   = 1'b1;
        use_rt   = 1'b1;
        if (func == FUNC_JR) d_jp = 1'b1;
        else                 d_we_raw = 1'b1;
      end
      OP_ADDI, OP_ADDIU, OP_LW: begin
        d_first  = rs_val;
        d_second = sext_imm;
        d_waddr  = rt;
        d_we_raw = 1'b1;
        d_mr     = (opcode == OP_LW);
        use_rs   = 1'b1;
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        d_first  = rs_val;
        d_second = zext_imm;
        d_waddr  = rt;
        d_we_raw = 1'b1;
        use_rs   = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        d_first  = rs_val;
        d_second = rt_val;
        d_br     = 1'b1;
        d_target = br_target;
        use_rs   = 1'b1;
        use_rt   = 1'b1;
      end
      OP_SW: begin
        d_first  = rs_val;
        d_second = sext_imm;
        d_mw     = 1'b1;
        use_rs   = 1'b1;
        use_rt   = 1'b1;
      end
      OP_JAL: begin
        d_first  = pc4;
        d_waddr  = 5'd31;
        d_we_raw = 1'b1;
        d_jp     = 1'b1;
        d_target = j_target;
      end
      OP_J: begin
        d_jp     = 1'b1;
        d_target = j_target;
      end
      default: d_illegal = 1'b1;
    endcase
    d_we = d_we_raw && (d_waddr != 5'd0);
  end

  logic hazard, accept, stall_bubble;

  assign hazard = ex_if.ex_valid && ex_if.ex_mem_read && (ex_if.ex_waddr != 5'd0) &&
                  ((use_rs && ex_if.ex_waddr == rs) || (use_rt && ex_if.ex_waddr == rt));

  // A stall lasts exactly one cycle: by then the load sits in MEM/WB and is forwarded.
  always_comb begin
    state_next   = state;
    id_ready     = 1'b1;
    accept       = 1'b0;
    stall_bubble = 1'b0;
    if (flush) begin
      state_next = RUN;
    end else if (state == RUN && if_valid && hazard) begin
      id_ready     = 1'b0;
      stall_bubble = 1'b1;
      state_next   = STALL;
    end else begin
      accept     = if_valid;
      state_next = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state                <= RUN;
      illegal_instr        <= 1'b0;
      stall_count          <= '0;
      ex_if.ex_valid       <= 1'b0;
      ex_if.ex_opcode      <= 6'd0;
      ex_if.ex_func        <= 6'd0;
      ex_if.ex_sa          <= 5'd0;
      ex_if.ex_first_val   <= 32'd0;
      ex_if.ex_second_val  <= 32'd0;
      ex_if.ex_store_data  <= 32'd0;
      ex_if.ex_waddr       <= 5'd0;
      ex_if.ex_we          <= 1'b0;
      ex_if.ex_mem_read    <= 1'b0;
      ex_if.ex_mem_write   <= 1'b0;
      ex_if.ex_is_branch   <= 1'b0;
      ex_if.ex_is_jump     <= 1'b0;
      ex_if.ex_target      <= 32'd0;
    end else begin
      state         <= state_next;
      illegal_instr <= accept && d_illegal;
      if (stall_bubble && stall_count != {STALL_CNT_W{1'b1}})
        stall_count <= stall_count + 1'b1;
      if (accept && !d_illegal) begin
        ex_if.ex_valid      <= 1'b1;
        ex_if.ex_opcode     <= opcode;
        ex_if.ex_func       <= func;
        ex_if.ex_sa         <= if_instr[10:6];
        ex_if.ex_first_val  <= d_first;
        ex_if.ex_second_val <= d_second;
        ex_if.ex_store_data <= rt_val;
        ex_if.ex_waddr      <= d_waddr;
        ex_if.ex_we         <= d_we;
        ex_if.ex_mem_read   <= d_mr;
        ex_if.ex_mem_write  <= d_mw;
        ex_if.ex_is_branch  <= d_br;
        ex_if.ex_is_jump    <= d_jp;
        ex_if.ex_target     <= d_target;
      end else begin
        ex_if.ex_valid      <= 1'b0;
        ex_if.ex_opcode     <= 6'd0;
        ex_if.ex_func       <= 6'd0;
        ex_if.ex_sa         <= 5'd0;
        ex_if.ex_first_val  <= 32'd0;
        ex_if.ex_second_val <= 32'd0;
        ex_if.ex_store_data <= 32'd0;
        ex_if.ex_waddr      <= 5'd0;
        ex_if.ex_we         <= 1'b0;
        ex_if.ex_mem_read   <= 1'b0;
        ex_if.ex_mem_write  <= 1'b0;
        ex_if.ex_is_branch  <= 1'b0;
        ex_if.ex_is_jump    <= 1'b0;
        ex_if.ex_target     <= 32'd0;
      end
    end
  end

endmodule

// File: tb/tb_decode_issue.sv
// Directed bench for decode_issue: a table of single-instruction vectors plus
// hand-written load-use, no-hazard and flush sequences.
module tb_decode_issue;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_valid;
  logic [31:0] if_instr, if_pc;
  logic        id_ready;
  logic        flush;
  logic [4:0]  rf_raddr1, rf_raddr2;
  logic [31:0] rf_rdata1, rf_rdata2;
  logic        fwd_ex_we, fwd_mem_we;
  logic [4:0]  fwd_ex_waddr, fwd_mem_waddr;
  logic [31:0] fwd_ex_wdata, fwd_mem_wdata;
  logic        illegal_instr;
  logic [15:0] stall_count;

  int nchecks = 0;
  int nerrors = 0;

  decode_issue_if ex_if();

  decode_issue #(.STALL_CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .id_ready(id_ready),
    .flush(flush),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .fwd_ex_we(fwd_ex_we), .fwd_ex_waddr(fwd_ex_waddr), .fwd_ex_wdata(fwd_ex_wdata),
    .fwd_mem_we(fwd_mem_we), .fwd_mem_waddr(fwd_mem_waddr), .fwd_mem_wdata(fwd_mem_wdata),
    .ex_if(ex_if),
    .illegal_instr(illegal_instr), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr, pc, rd1, rd2;
    logic        fe_we;
    logic [4:0]  fe_a;
    logic [31:0] fe_d;
    logic        fm_we;
    logic [4:0]  fm_a;
    logic [31:0] fm_d;
    logic        valid;
    logic [31:0] first, second, store;
    logic [4:0]  waddr;
    logic        we, mr, mw, br, jp;
    logic [31:0] target;
    logic        ill;
  } vec_t;

  vec_t vecs[$];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic clearInputs();
    if_valid = 1'b0; if_instr = 32'd0; if_pc = 32'd0; flush = 1'b0;
    rf_rdata1 = 32'd0; rf_rdata2 = 32'd0;
    fwd_ex_we = 1'b0; fwd_ex_waddr = 5'd0; fwd_ex_wdata = 32'd0;
    fwd_mem_we = 1'b0; fwd_mem_waddr = 5'd0; fwd_mem_wdata = 32'd0;
  endtask

  task automatic applyStimulus(input vec_t v);
    if_valid = 1'b1; if_instr = v.instr; if_pc = v.pc;
    rf_rdata1 = v.rd1; rf_rdata2 = v.rd2;
    fwd_ex_we = v.fe_we; fwd_ex_waddr = v.fe_a; fwd_ex_wdata = v.fe_d;
    fwd_mem_we = v.fm_we; fwd_mem_waddr = v.fm_a; fwd_mem_wdata = v.fm_d;
  endtask

  task automatic drive(input logic [31:0] instr, input logic [31:0] rd1, input logic [31:0] rd2);
    clearInputs();
    if_valid = 1'b1; if_instr = instr; rf_rdata1 = rd1; rf_rdata2 = rd2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkVector(input int idx, input vec_t v);
    logic [31:0] ins;
    string tag;
    ins = v.instr;
    tag = $sformatf("v%0d", idx);
    checkOutput({tag, ".valid"},     {31'd0, ex_if.ex_valid},     {31'd0, v.valid});
    checkOutput({tag, ".we"},        {31'd0, ex_if.ex_we},        {31'd0, v.we});
    checkOutput({tag, ".mem_read"},  {31'd0, ex_if.ex_mem_read},  {31'd0, v.mr});
    checkOutput({tag, ".mem_write"}, {31'd0, ex_if.ex_mem_write}, {31'd0, v.mw});
    checkOutput({tag, ".is_branch"}, {31'd0, ex_if.ex_is_branch}, {31'd0, v.br});
    checkOutput({tag, ".is_jump"},   {31'd0, ex_if.ex_is_jump},   {31'd0, v.jp});
    checkOutput({tag, ".illegal"},   {31'd0, illegal_instr},      {31'd0, v.ill});
    if (v.valid) begin
      checkOutput({tag, ".opcode"}, {26'd0, ex_if.ex_opcode}, {26'd0, ins[31:26]});
      checkOutput({tag, ".func"},   {26'd0, ex_if.ex_func},   {26'd0, ins[5:0]});
      checkOutput({tag, ".sa"},     {27'd0, ex_if.ex_sa},     {27'd0, ins[10:6]});
      checkOutput({tag, ".first"},  ex_if.ex_first_val,  v.first);
      checkOutput({tag, ".second"}, ex_if.ex_second_val, v.second);
      if (v.we) checkOutput({tag, ".waddr"}, {27'd0, ex_if.ex_waddr}, {27'd0, v.waddr});
      if (v.mw) checkOutput({tag, ".store"}, ex_if.ex_store_data, v.store);
      if (v.br || v.jp) checkOutput({tag, ".target"}, ex_if.ex_target, v.target);
    end
  endtask

  initial begin
    //            instr         pc            rd1           rd2        fe_we fe_a  fe_d        fm_we fm_a  fm_d        valid first        second        store      waddr  we   mr   mw   br   jp   target        ill
    vecs.push_back('{32'h2109FFFC, 32'h0,        32'd10,       32'h0,     1'b0, 5'd0, 32'h0,      1'b0, 5'd0, 32'h0,      1'b1, 32'd10,      32'hFFFFFFFC, 32'h0,     5'd9,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0});
    vecs.push_back('{32'h35098000, 32'h0,        32'd3,        32'h0,     1'b0, 5'd0, 32'h0,      1'b0, 5'd0, 32'h0,      1'b1, 32'd3,       32'h00008000, 32'h0,     5'd9,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0});
    vecs.push_back('{32'h34A98000, 32'h0,        32'd1,        32'h0,     1'b1, 5'd5, 32'd7,      1'b1, 5'd5, 32'd9,      1'b1, 32'd7,       32'h00008000, 32'h0,     5'd9,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0});
    vecs.push_back('{32'h34A98000, 32'h0,        32'd1,        32'h0,     1'b0, 5'd5, 32'd7,      1'b1, 5'd5, 32'd9,      1'b1, 32'd9,       32'h00008000, 32'h0,     5'd9,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0});
    vecs.push_back('{32'h34A98000, 32'h0,        32'd1,        32'h0,     1'b1, 5'd6, 32'd7,      1'b0, 5'd5, 32'd9,      1'b1, 32'd1,       32'h00008000, 32'h0,     5'd9,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0});
    vecs.push_back('{32'h34098000, 32'h0,        32'd1,        32'h0,     1'b1, 5'd0, 32'd7,      1'b1, 5'd0, 32'd9,      1'b1, 32'd0,       32'h00008000, 32'h0,     5'd9,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0});
    vecs.push_back('{32'h00452020, 32'h0,        32'h11,       32'h22,    1'b0, 5'd0, 32'h0,      1'b1, 5'd5, 32'h99,     1'b1, 32'h11,      32'h99,       32'h0,     5'd4,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0});
    vecs.push_back('{32'h00450020, 32'h0,        32'h11,       32'h22,    1'b0, 5'd0, 32'h0,      1'b0, 5'd0, 32'h0,      1'b1, 32'h11,      32'h22,       32'h0,     5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0});
    vecs.push_back('{32'h000208C0, 32'h0,        32'h77,       32'h22,    1'b0, 5'd0, 32'h0,      1'b0, 5'd0, 32'h0,      1'b1, 32'h0,       32'h22,       32'h0,     5'd1,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0});
    vecs.push_back('{32'h10220003, 32'h200,      32'd5,        32'd6,     1'b0, 5'd0, 32'h0,      1'b0, 5'd0, 32'h0,      1'b1, 32'd5,       32'd6,        32'h0,     5'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h210,      1'b0});
    vecs.push_back('{32'h1422FFFF, 32'h200,      32'd5,        32'd6,     1'b0, 5'd0, 32'h0,      1'b0, 5'd0, 32'h0,      1'b1, 32'd5,       32'd6,        32'h0,     5'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h200,      1'b0});
    vecs.push_back('{32'h8C620010, 32'h0,        32'h1000,     32'h0,     1'b0, 5'd0, 32'h0,      1'b0, 5'd0, 32'h0,      1'b1, 32'h1000,    32'h10,       32'h0,     5'd2,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0});
    vecs.push_back('{32'hAC62FFF8, 32'h0,        32'h1000,     32'h55,    1'b0, 5'd0, 32'h0,      1'b0, 5'd0, 32'h0,      1'b1, 32'h1000,    32'hFFFFFFF8, 32'h55,    5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0});
    vecs.push_back('{32'h0C000010, 32'h100,      32'h0,        32'h0,     1'b0, 5'd0, 32'h0,      1'b0, 5'd0, 32'h0,      1'b1, 32'h104,     32'h0,        32'h0,     5'd31, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h40,       1'b0});
    vecs.push_back('{32'h08000010, 32'hF0000100, 32'h0,        32'h0,     1'b0, 5'd0, 32'h0,      1'b0, 5'd0, 32'h0,      1'b1, 32'h0,       32'h0,        32'h0,     5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hF0000040, 1'b0});
    vecs.push_back('{32'h03E00008, 32'h0,        32'h1234,     32'h9,     1'b0, 5'd0, 32'h0,      1'b0, 5'd0, 32'h0,      1'b1, 32'h1234,    32'h0,        32'h0,     5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0,        1'b0});
    vecs.push_back('{32'h3821FFFF, 32'h0,        32'hF0,       32'h0,     1'b0, 5'd0, 32'h0,      1'b0, 5'd0, 32'h0,      1'b1, 32'hF0,      32'h0000FFFF, 32'h0,     5'd1,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0});
    vecs.push_back('{32'h2421FFFF, 32'h0,        32'd2,        32'h0,     1'b0, 5'd0, 32'h0,      1'b0, 5'd0, 32'h0,      1'b1, 32'd2,       32'hFFFFFFFF, 32'h0,     5'd1,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0});
    vecs.push_back('{32'hFC000000, 32'h0,        32'h0,        32'h0,     1'b0, 5'd0, 32'h0,      1'b0, 5'd0, 32'h0,      1'b0, 32'h0,       32'h0,        32'h0,     5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b1});

    clearInputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset.ex_valid",    {31'd0, ex_if.ex_valid}, 32'd0);
    checkOutput("reset.ex_we",       {31'd0, ex_if.ex_we}, 32'd0);
    checkOutput("reset.ex_first",    ex_if.ex_first_val, 32'd0);
    checkOutput("reset.ex_second",   ex_if.ex_second_val, 32'd0);
    checkOutput("reset.ex_target",   ex_if.ex_target, 32'd0);
    checkOutput("reset.ex_opcode",   {26'd0, ex_if.ex_opcode}, 32'd0);
    checkOutput("reset.ex_ctrl",     {28'd0, ex_if.ex_mem_read, ex_if.ex_mem_write,
                                      ex_if.ex_is_branch, ex_if.ex_is_jump}, 32'd0);
    checkOutput("reset.stall_count", {16'd0, stall_count}, 32'd0);
    checkOutput("reset.illegal",     {31'd0, illegal_instr}, 32'd0);
    checkOutput("reset.id_ready",    {31'd0, id_ready}, 32'd1);
    reset = 1'b0;

    foreach (vecs[i]) begin
      logic [31:0] ins;
      ins = vecs[i].instr;
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("v%0d.raddr1", i), {27'd0, rf_raddr1}, {27'd0, ins[25:21]});
      checkOutput($sformatf("v%0d.raddr2", i), {27'd0, rf_raddr2}, {27'd0, ins[20:16]});
      checkOutput($sformatf("v%0d.id_ready", i), {31'd0, id_ready}, 32'd1);
      tick();
      checkVector(i, vecs[i]);
      clearInputs();
      tick();
      checkOutput($sformatf("v%0d.idle_valid", i), {31'd0, ex_if.ex_valid}, 32'd0);
      checkOutput($sformatf("v%0d.idle_illegal", i), {31'd0, illegal_instr}, 32'd0);
    end

    // Load-use: lw $2,0($3) then add $4,$2,$5
    drive(32'h8C620000, 32'h2000, 32'h0);
    tick();
    checkOutput("lu.lw_mem_read", {31'd0, ex_if.ex_mem_read}, 32'd1);
    drive(32'h00452020, 32'hDEAD, 32'h5);
    #1;
    checkOutput("lu.id_ready_low", {31'd0, id_ready}, 32'd0);
    tick();
    checkOutput("lu.bubble_valid", {31'd0, ex_if.ex_valid}, 32'd0);
    checkOutput("lu.bubble_we",    {31'd0, ex_if.ex_we}, 32'd0);
    checkOutput("lu.stall_count",  {16'd0, stall_count}, 32'd1);
    checkOutput("lu.stall_ready",  {31'd0, id_ready}, 32'd1);
    fwd_mem_we = 1'b1; fwd_mem_waddr = 5'd2; fwd_mem_wdata = 32'hABCD;
    tick();
    checkOutput("lu.add_valid",   {31'd0, ex_if.ex_valid}, 32'd1);
    checkOutput("lu.add_first",   ex_if.ex_first_val, 32'hABCD);
    checkOutput("lu.add_second",  ex_if.ex_second_val, 32'h5);
    checkOutput("lu.count_after", {16'd0, stall_count}, 32'd1);
    clearInputs();
    tick();

    // lw $2 followed by jal, which reads no registers: no stall
    drive(32'h8C620000, 32'h2000, 32'h0);
    tick();
    drive(32'h0C000010, 32'h0, 32'h0);
    #1;
    checkOutput("nh.id_ready", {31'd0, id_ready}, 32'd1);
    tick();
    checkOutput("nh.valid", {31'd0, ex_if.ex_valid}, 32'd1);
    checkOutput("nh.count", {16'd0, stall_count}, 32'd1);
    clearInputs();
    tick();

    // lw $2 then sw $2,0($3) (hazard via rt), killed by flush
    drive(32'h8C620000, 32'h2000, 32'h0);
    tick();
    drive(32'hAC620000, 32'h1000, 32'h7);
    #1;
    checkOutput("fl.rt_hazard", {31'd0, id_ready}, 32'd0);
    flush = 1'b1;
    #1;
    checkOutput("fl.id_ready", {31'd0, id_ready}, 32'd1);
    tick();
    checkOutput("fl.valid",   {31'd0, ex_if.ex_valid}, 32'd0);
    checkOutput("fl.mem_wr",  {31'd0, ex_if.ex_mem_write}, 32'd0);
    checkOutput("fl.count",   {16'd0, stall_count}, 32'd1);
    checkOutput("fl.illegal", {31'd0, illegal_instr}, 32'd0);
    drive(32'h00452020, 32'h3, 32'h4);
    tick();
    checkOutput("fl.next_valid", {31'd0, ex_if.ex_valid}, 32'd1);
    checkOutput("fl.next_first", ex_if.ex_first_val, 32'h3);
    checkOutput("fl.next_count", {16'd0, stall_count}, 32'd1);
    clearInputs();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
